// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table and sizing helpers for the seven-segment scan driver
package seg7_pkg;

    // All segments off (segments are active-low).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment patterns indexed by 4-bit code; bit0 = a .. bit6 = g.
    localparam logic [6:0] GLYPH [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Digit index width; a single-digit display still needs one bit.
    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - load bus from the producer's output register into the scan driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    neg_in;
    logic                    hex_en;
    logic                    blank_lz;

    modport master (
        output load,
        output value_in,
        output neg_in,
        output hex_en,
        output blank_lz
    );

    modport slave (
        input load,
        input value_in,
        input neg_in,
        input hex_en,
        input blank_lz
    );
endinterface

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational decode of one 4-bit code into an active-low segment pattern
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blanked digits and hex codes without hex mode render dark.
    always_comb begin
        seg = GLYPH[code];
        if (blank || (!hex_en && code > 4'd9)) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit common-anode seven-segment driver
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_driver_if.slave     host,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  neg_out,
    output logic                  frame_done
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic                    neg_q, neg_d;
    logic                    hex_en_q, hex_en_d;
    logic                    blank_lz_q, blank_lz_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    presc_wrap;
    logic                    idx_last;
    logic                    in_guard;
    logic [3:0]              digit;
    logic                    upper_zero;
    logic                    lz_blank;
    logic [6:0]              glyph_seg;

    // Shadow capture: the display only ever sees what was latched on load.
    always_comb begin
        value_d    = value_q;
        neg_d      = neg_q;
        hex_en_d   = hex_en_q;
        blank_lz_d = blank_lz_q;
        if (host.load) begin
            value_d    = host.value_in;
            neg_d      = host.neg_in;
            hex_en_d   = host.hex_en;
            blank_lz_d = host.blank_lz;
        end
    end

    // Slot prescaler and digit index; frame_done marks the index wrapping back to 0.
    always_comb begin
        presc_wrap   = (presc_q == PW'(REFRESH_DIV - 1));
        idx_last     = (idx_q == IW'(NUM_DIGITS - 1));
        presc_d      = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        if (presc_wrap) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
        end
        frame_done_d = presc_wrap && idx_last;
    end

    // Pick the current digit and decide whether it is a leading zero to suppress.
    always_comb begin
        digit      = value_q[{idx_q, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IW'(j) >= idx_q && value_q[4*j +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        lz_blank = blank_lz_q && (idx_q != '0) && upper_zero;
    end

    seg7_glyph u_glyph (
        .code   (digit),
        .hex_en (hex_en_q),
        .blank  (lz_blank),
        .seg    (glyph_seg)
    );

    // Output stage: dark during the guard interval so the previous digit cannot ghost.
    always_comb begin
        in_guard = (presc_q < PW'(GUARD));
        seg_d    = in_guard ? SEG_BLANK : glyph_seg;
        an_d     = '1;
        if (!in_guard) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                an_d[j] = (IW'(j) != idx_q);
            end
        end
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            value_q      <= '0;
            neg_q        <= 1'b0;
            hex_en_q     <= 1'b0;
            blank_lz_q   <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            value_q      <= value_d;
            neg_q        <= neg_d;
            hex_en_q     <= hex_en_d;
            blank_lz_q   <= blank_lz_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign neg_out    = neg_q;
    assign frame_done = frame_done_q;

endmodule
